alu_issue_ctrl: RTL and testbench

Initiator side of the ALU interface. Accepts one decoded MIPS-subset instruction per valid/ready handshake and maps opcode/funct to the 3-bit ALU control code. Drives registered S/T/Ctr to the combinational ALU, captures its Result one cycle later, and returns the result plus branch and illegal flags through an output valid/ready handshake.

---
 rtl/alu_issue_ctrl_pkg.sv | 34 +++
 rtl/alu_op_decode.sv | 63 ++++++
 rtl/alu_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared ALU codes, MIPS-subset opcode/funct values and FSM encoding
package alu_issue_ctrl_pkg;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_EQ  = 3'b110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode/funct to ALU control decode
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] ctr,
    output logic       use_imm,
    output logic       sign_ext,
    output logic       is_beq,
    output logic       is_bne,
    output logic       illegal
);

    always_comb begin
        ctr      = ALU_NOP;
        use_imm  = 1'b0;
        sign_ext = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctr = ALU_ADD;
                    FN_SUB:  ctr = ALU_SUB;
                    FN_AND:  ctr = ALU_AND;
                    FN_OR:   ctr = ALU_OR;
                    FN_SLT:  ctr = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                ctr      = ALU_ADD;
                use_imm  = 1'b1;
                sign_ext = 1'b1;
            end
            OP_SLTI: begin
                ctr      = ALU_SLT;
                use_imm  = 1'b1;
                sign_ext = 1'b1;
            end
            OP_ANDI: begin
                ctr     = ALU_AND;
                use_imm = 1'b1;
            end
            OP_ORI: begin
                ctr     = ALU_OR;
                use_imm = 1'b1;
            end
            OP_BEQ: begin
                ctr    = ALU_EQ;
                is_beq = 1'b1;
            end
            OP_BNE: begin
                ctr    = ALU_EQ;
                is_bne = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one decoded instruction to the ALU and returns its result
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm,
    output logic [WIDTH-1:0] alu_s,
    output logic [WIDTH-1:0] alu_t,
    output logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_taken,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);

    state_t state, state_nxt;

    logic [2:0]       dec_ctr;
    logic             dec_use_imm;
    logic             dec_sign_ext;
    logic             dec_beq;
    logic             dec_bne;
    logic             dec_illegal;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] t_sel;
    logic             br_beq;
    logic             br_bne;
    logic             accept;
    logic             consume;

    alu_op_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .ctr      (dec_ctr),
        .use_imm  (dec_use_imm),
        .sign_ext (dec_sign_ext),
        .is_beq   (dec_beq),
        .is_bne   (dec_bne),
        .illegal  (dec_illegal)
    );

    assign imm_ext = dec_sign_ext ? {{(WIDTH-16){imm[15]}}, imm} : {{(WIDTH-16){1'b0}}, imm};
    assign t_sel   = dec_use_imm ? imm_ext : rt_val;
    assign accept  = (state == ST_IDLE) && in_valid;
    assign consume = (state == ST_RESP) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = dec_illegal ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Illegal instructions bypass EXEC, so the response fields are loaded at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s       <= '0;
            alu_t       <= '0;
            alu_ctr     <= ALU_NOP;
            br_beq      <= 1'b0;
            br_bne      <= 1'b0;
            out_result  <= '0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                if (dec_illegal) begin
                    out_result  <= '0;
                    out_taken   <= 1'b0;
                    out_illegal <= 1'b1;
                end else begin
                    alu_s   <= rs_val;
                    alu_t   <= t_sel;
                    alu_ctr <= dec_ctr;
                    br_beq  <= dec_beq;
                    br_bne  <= dec_bne;
                end
            end
            if (state == ST_EXEC) begin
                out_result  <= alu_result;
                out_taken   <= (br_beq & alu_result[0]) | (br_bne & ~alu_result[0]);
                out_illegal <= 1'b0;
                alu_ctr     <= ALU_NOP;
            end
            if (consume) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic [31:0] alu_s;
    logic [31:0] alu_t;
    logic [2:0]  alu_ctr;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_taken;
    logic        out_illegal;
    logic [15:0] op_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .imm         (imm),
        .alu_s       (alu_s),
        .alu_t       (alu_t),
        .alu_ctr     (alu_ctr),
        .alu_result  (alu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_taken   (out_taken),
        .out_illegal (out_illegal),
        .op_count    (op_count)
    );

    // Combinational ALU the block talks to
    logic [31:0] diff;
    always_comb begin
        diff       = alu_s - alu_t;
        alu_result = 32'h0;
        case (alu_ctr)
            3'b001:  alu_result = alu_s + alu_t;
            3'b010:  alu_result = diff;
            3'b011:  alu_result = alu_s & alu_t;
            3'b100:  alu_result = alu_s | alu_t;
            3'b101:  alu_result = {31'h0, diff[31]};
            3'b110:  alu_result = {31'h0, alu_s == alu_t};
            default: alu_result = 32'h0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_legal(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                             input logic [2:0] ectr, input logic [31:0] et, input logic [31:0] eres,
                             input logic etk, input logic [15:0] ecnt);
        opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm = im; in_valid = 1'b1;
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        rs_val = 32'hDEADBEEF; rt_val = 32'h12345678; imm = 16'hA5A5;
        chk({tag, "_exec_ctr"}, alu_ctr, ectr);
        chk({tag, "_exec_s"}, alu_s, rs);
        chk({tag, "_exec_t"}, alu_t, et);
        chk({tag, "_exec_valid"}, out_valid, 0);
        chk({tag, "_exec_in_ready"}, in_ready, 0);
        step();
        chk({tag, "_resp_valid"}, out_valid, 1);
        chk({tag, "_resp_result"}, out_result, eres);
        chk({tag, "_resp_taken"}, out_taken, etk);
        chk({tag, "_resp_illegal"}, out_illegal, 0);
        chk({tag, "_resp_ctr_nop"}, alu_ctr, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_count"}, op_count, ecnt);
        chk({tag, "_done_in_ready"}, in_ready, 1);
    endtask

    task automatic run_illegal(input string tag, input logic [5:0] op, input logic [5:0] fn,
                               input logic [15:0] ecnt);
        opcode = op; funct = fn; rs_val = 32'h11111111; rt_val = 32'h22222222; imm = 16'h3333;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_illegal"}, out_illegal, 1);
            chk({tag, "_result"}, out_result, 0);
            chk({tag, "_taken"}, out_taken, 0);
            chk({tag, "_ctr"}, alu_ctr, 0);
            chk({tag, "_in_ready"}, in_ready, 0);
            chk({tag, "_count_hold"}, op_count, ecnt - 16'd1);
            if (i < 3) step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_count"}, op_count, ecnt);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 6'h0; funct = 6'h0; rs_val = 32'h0; rt_val = 32'h0; imm = 16'h0;
        #2;
        chk("rst_alu_s", alu_s, 0);
        chk("rst_alu_t", alu_t, 0);
        chk("rst_alu_ctr", alu_ctr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_taken", out_taken, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_op_count", op_count, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        run_legal("add",  6'h00, 6'h20, 32'd5,        32'd7, 16'h0000, 3'b001, 32'd7,        32'd12,       1'b0, 16'd1);
        run_legal("slti", 6'h0A, 6'h00, 32'hFFFFFFFF, 32'd9, 16'h0001, 3'b101, 32'h00000001, 32'd1,        1'b0, 16'd2);
        run_legal("addi", 6'h08, 6'h00, 32'd1,        32'd9, 16'hFFFF, 3'b001, 32'hFFFFFFFF, 32'd0,        1'b0, 16'd3);
        run_legal("andi", 6'h0C, 6'h00, 32'hFFFFFFFF, 32'd9, 16'h8000, 3'b011, 32'h00008000, 32'h00008000, 1'b0, 16'd4);
        run_legal("ori",  6'h0D, 6'h00, 32'h0,        32'd9, 16'h8000, 3'b100, 32'h00008000, 32'h00008000, 1'b0, 16'd5);
        run_legal("bne",  6'h05, 6'h00, 32'd3,        32'd3, 16'h0000, 3'b110, 32'd3,        32'd1,        1'b0, 16'd6);
        run_legal("beq",  6'h04, 6'h00, 32'd3,        32'd3, 16'h0000, 3'b110, 32'd3,        32'd1,        1'b1, 16'd7);
        run_legal("bne_t",6'h05, 6'h00, 32'd3,        32'd4, 16'h0000, 3'b110, 32'd4,        32'd0,        1'b1, 16'd8);
        run_legal("lw",   6'h23, 6'h00, 32'h100,      32'd9, 16'hFFFC, 3'b001, 32'hFFFFFFFC, 32'h000000FC, 1'b0, 16'd9);
        run_legal("slt",  6'h00, 6'h2A, 32'd2,        32'd3, 16'h0000, 3'b101, 32'd3,        32'd1,        1'b0, 16'd10);
        run_legal("or",   6'h00, 6'h25, 32'hF0,       32'h0F,16'h0000, 3'b100, 32'h0F,       32'hFF,       1'b0, 16'd11);

        run_illegal("ill_op3f", 6'h3F, 6'h00, 16'd12);
        run_illegal("ill_fn21", 6'h00, 6'h21, 16'd13);

        // Reset during EXEC of sub 9-4
        opcode = 6'h00; funct = 6'h22; rs_val = 32'd9; rt_val = 32'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("abort_exec_ctr", alu_ctr, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctr", alu_ctr, 0);
        chk("abort_s", alu_s, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_result", out_result, 0);
        chk("abort_count", op_count, 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_abort_valid", out_valid, 0);
            chk("post_abort_in_ready", in_ready, 1);
            chk("post_abort_count", op_count, 0);
        end
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
